// File: rtl/ifu_prefetch.sv
// Instruction prefetch queue: issues sequential ROM reads and buffers {pc, inst} pairs in a
// small FIFO, presented to the fetch stage over valid/ready; a flush redirects the fetch stream.
module ifu_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [31:0]              rom_addr_o,
  output logic                     rom_en_o,
  input  logic [31:0]              rom_inst_i,
  input  logic                     flush_i,
  input  logic [31:0]              flush_addr_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [31:0]              out_pc_o,
  output logic [31:0]              out_inst_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc_reg;
  logic [31:0]   req_pc_reg;
  logic          inflight_reg;
  logic [CW-1:0] count_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic [CW:0]   credit_used;
  logic          issue;
  logic          push;
  logic          pop;

  // Credits include the outstanding request so a returning word always has a free slot.
  assign credit_used = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};
  assign issue       = ~rst & ~flush_i & (credit_used < (CW+1)'(DEPTH));
  assign push        = inflight_reg & ~flush_i & ~rst;
  assign pop         = out_valid_o & out_ready_i & ~flush_i & ~rst;

  assign rom_en_o    = issue;
  assign rom_addr_o  = fetch_pc_reg;
  assign count_o     = count_reg;
  assign out_valid_o = (count_reg != '0);
  assign out_pc_o    = out_valid_o ? pc_mem[rd_ptr_reg]   : 32'h0;
  assign out_inst_o  = out_valid_o ? inst_mem[rd_ptr_reg] : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg <= RESET_PC;
      req_pc_reg   <= 32'h0;
      inflight_reg <= 1'b0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else if (flush_i) begin
      // Clearing inflight drops the return of any pre-flush request.
      fetch_pc_reg <= flush_addr_i;
      inflight_reg <= 1'b0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        fetch_pc_reg <= fetch_pc_reg + 32'd4;
        req_pc_reg   <= fetch_pc_reg;
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == AW'(gi))) begin
          pc_mem[gi]   <= req_pc_reg;
          inst_mem[gi] <= rom_inst_i;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch; the ROM model returns ~addr so pc/inst mix-ups show up.
module tb_ifu_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] rom_addr;
  logic        rom_en;
  logic [31:0] rom_inst = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] flush_addr = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  count;

  int vectors = 0;
  int miscompares = 0;

  ifu_prefetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .rom_addr_o(rom_addr), .rom_en_o(rom_en), .rom_inst_i(rom_inst),
    .flush_i(flush), .flush_addr_i(flush_addr),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_pc_o(out_pc), .out_inst_o(out_inst), .count_o(count)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (rom_en) rom_inst <= ~rom_addr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int issues;
    logic [31:0] e;

    // Reset state
    tick(); tick(); #1;
    chk("rst_en", 32'(rom_en), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_inst", out_inst, 0);

    // Ready low from reset: exactly four issues fill the FIFO
    rst = 1'b0; #1;
    issues = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      if (rom_en) begin
        chk("fill_addr", rom_addr, 32'(issues * 4));
        issues++;
      end
    end
    chk("fill_issues", 32'(issues), 4);
    chk("fill_count", 32'(count), 4);
    chk("fill_en", 32'(rom_en), 0);

    // Drain from full with ready every cycle: continuous in-order stream
    tick(); out_ready = 1'b1; #1;
    chk("full_count", 32'(count), 4);
    chk("full_en", 32'(rom_en), 0);
    for (int k = 0; k < 10; k++) begin
      chk("drain_valid", 32'(out_valid), 1);
      chk("drain_pc", out_pc, 32'(k * 4));
      chk("drain_inst", out_inst, ~32'(k * 4));
      if (k == 1) begin
        chk("resume_en", 32'(rom_en), 1);
        chk("resume_addr", rom_addr, 32'h10);
      end
      tick();
    end

    // Flush with three buffered and one in flight
    tick(); rst = 1'b1; out_ready = 1'b0; #1;
    chk("rst2_en", 32'(rom_en), 0);
    tick(); rst = 1'b0; #1;
    tick(); tick(); tick();
    chk("pre_flush_addr", rom_addr, 32'hC);
    tick();
    chk("pre_flush_count", 32'(count), 3);
    chk("pre_flush_en", 32'(rom_en), 0);
    flush = 1'b1; flush_addr = 32'h100; #1;
    chk("flush_en", 32'(rom_en), 0);
    tick(); flush_addr = 32'h200; #1;
    chk("flush_hold_count", 32'(count), 0);
    chk("flush_hold_valid", 32'(out_valid), 0);
    chk("flush_hold_en", 32'(rom_en), 0);
    tick(); flush = 1'b0; #1;
    chk("redir_count", 32'(count), 0);
    chk("redir_en", 32'(rom_en), 1);
    chk("redir_addr", rom_addr, 32'h200);
    tick();
    chk("redir_count1", 32'(count), 0);
    chk("redir_addr1", rom_addr, 32'h204);
    tick();
    chk("redir_pc", out_pc, 32'h200);
    chk("redir_inst", out_inst, ~32'h200);
    chk("redir_count2", 32'(count), 1);
    tick();
    chk("half_count", 32'(count), 2);

    // Reset mid-operation with a request in flight
    rst = 1'b1; #1;
    chk("midrst_en", 32'(rom_en), 0);
    tick();
    chk("midrst_count", 32'(count), 0);
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_pc", out_pc, 0);
    chk("midrst_inst", out_inst, 0);

    // Streaming with ready high from reset
    rst = 1'b0; out_ready = 1'b1; #1;
    chk("s_addr0", rom_addr, 32'h0);
    chk("s_en0", 32'(rom_en), 1);
    chk("s_valid0", 32'(out_valid), 0);
    tick();
    chk("s_addr1", rom_addr, 32'h4);
    chk("s_valid1", 32'(out_valid), 0);
    tick();
    for (int i = 0; i <= 10; i++) begin
      e = 32'(i * 4);
      chk("s_valid", 32'(out_valid), 1);
      chk("s_pc", out_pc, e);
      chk("s_inst", out_inst, ~e);
      chk("s_addr", rom_addr, e + 32'd8);
      tick();
    end

    // Fetch address wrap at the top of the address space
    flush = 1'b1; flush_addr = 32'hFFFF_FFF8; #1;
    chk("wrap_flush_en", 32'(rom_en), 0);
    tick(); flush = 1'b0; #1;
    chk("wrap_addr0", rom_addr, 32'hFFFF_FFF8);
    tick();
    chk("wrap_addr1", rom_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr2", rom_addr, 32'h0);
    chk("wrap_pc0", out_pc, 32'hFFFF_FFF8);
    tick();
    chk("wrap_pc1", out_pc, 32'hFFFF_FFFC);
    chk("wrap_addr3", rom_addr, 32'h4);
    tick();
    chk("wrap_pc2", out_pc, 32'h0);
    chk("wrap_inst2", out_inst, 32'hFFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
